// File: rtl/wb_sequencer.sv
// wb_sequencer: write-back sequencer feeding the register file's single write port.
//
// Merges ALU results and in-order load responses into one registered write per cycle.
// Issued loads park {rd, funct3} in a small FIFO so the returning memory word can be
// narrowed and sign/zero-extended. Also raises the decode hazard stall for any
// register that still has a write outstanding.
//
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   alu_valid/alu_we/alu_rd/alu_data      ALU result source (takes priority)
//   load_req_valid/_ready, load_rd/funct3 load issue -> pending FIFO push
//   load_resp_valid/_ready, load_resp_data load data return -> FIFO pop
//   dec_rs1/dec_rs2/dec_rd, hazard_stall  decode hazard check
//   RegWrite/write_reg_addr/write_reg_data registered register-file write port
//   resp_error                            sticky: response seen with FIFO empty
module wb_sequencer #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    input  logic              alu_we,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              load_req_valid,
    output logic              load_req_ready,
    input  logic [ADDR_W-1:0] load_rd,
    input  logic [2:0]        load_funct3,
    input  logic              load_resp_valid,
    output logic              load_resp_ready,
    input  logic [DATA_W-1:0] load_resp_data,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic [ADDR_W-1:0] dec_rd,
    output logic              hazard_stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_reg_addr,
    output logic [DATA_W-1:0] write_reg_data,
    output logic              resp_error
);
    localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

    // Pending-load FIFO; a per-entry valid bit gives full/empty and the hazard scan.
    logic [ADDR_W-1:0]   r_lq_rd [LQ_DEPTH];
    logic [2:0]          r_lq_f3 [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] r_lq_vld;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;

    logic              r_regwrite;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_resp_error;

    logic                w_empty;
    logic                w_full;
    logic                w_alu_acc;
    logic                w_ld_acc;
    logic                w_ld_wr;
    logic                w_push;
    logic [ADDR_W-1:0]   w_head_rd;
    logic [2:0]          w_head_f3;
    logic [DATA_W-1:0]   w_ld_ext;
    logic [LQ_DEPTH-1:0] w_vld_d;
    logic [ADDR_W-1:0]   w_src [3];

    assign w_empty   = ~|r_lq_vld;
    assign w_full    = &r_lq_vld;
    assign w_head_rd = r_lq_rd[r_rd_ptr];
    assign w_head_f3 = r_lq_f3[r_rd_ptr];

    assign w_alu_acc       = alu_valid & alu_we & (alu_rd != '0);
    assign load_resp_ready = ~w_empty & ~w_alu_acc;
    assign w_ld_acc        = load_resp_valid & load_resp_ready;
    // rd=0 loads still pop but never reach the register file.
    assign w_ld_wr         = w_ld_acc & (w_head_rd != '0);
    // Ready looks only at the registered occupancy; a same-cycle pop gives no credit.
    assign load_req_ready  = ~w_full;
    assign w_push          = load_req_valid & load_req_ready;

    assign RegWrite       = r_regwrite;
    assign write_reg_addr = r_waddr;
    assign write_reg_data = r_wdata;
    assign resp_error     = r_resp_error;

    always_comb begin
        w_ld_ext = load_resp_data;
        case (w_head_f3)
            3'b000:  w_ld_ext = {{(DATA_W-8){load_resp_data[7]}}, load_resp_data[7:0]};
            3'b001:  w_ld_ext = {{(DATA_W-16){load_resp_data[15]}}, load_resp_data[15:0]};
            3'b010:  w_ld_ext = {{(DATA_W-32){load_resp_data[31]}}, load_resp_data[31:0]};
            3'b100:  w_ld_ext = {{(DATA_W-8){1'b0}}, load_resp_data[7:0]};
            3'b101:  w_ld_ext = {{(DATA_W-16){1'b0}}, load_resp_data[15:0]};
            3'b110:  w_ld_ext = {{(DATA_W-32){1'b0}}, load_resp_data[31:0]};
            default: w_ld_ext = load_resp_data;
        endcase
    end

    // Push and pop never target the same slot: push needs !full, pop needs !empty.
    always_comb begin
        w_vld_d = r_lq_vld;
        if (w_ld_acc) w_vld_d[r_rd_ptr] = 1'b0;
        if (w_push)   w_vld_d[r_wr_ptr] = 1'b1;
    end

    assign w_src[0] = dec_rs1;
    assign w_src[1] = dec_rs2;
    assign w_src[2] = dec_rd;

    always_comb begin
        hazard_stall = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (w_src[s] != '0) begin
                // Write sitting on the port has not landed in the file yet.
                if (r_regwrite && (r_waddr == w_src[s])) hazard_stall = 1'b1;
                for (int i = 0; i < LQ_DEPTH; i++) begin
                    if (r_lq_vld[i] && (r_lq_rd[i] == w_src[s])) hazard_stall = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                r_lq_rd[i] <= '0;
                r_lq_f3[i] <= '0;
            end
            r_lq_vld <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_lq_vld <= w_vld_d;
            if (w_push) begin
                r_lq_rd[r_wr_ptr] <= load_rd;
                r_lq_f3[r_wr_ptr] <= load_funct3;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_ld_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_regwrite   <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_resp_error <= 1'b0;
        end else begin
            r_regwrite <= w_alu_acc | w_ld_wr;
            if (w_alu_acc) begin
                r_waddr <= alu_rd;
                r_wdata <= alu_data;
            end else if (w_ld_wr) begin
                r_waddr <= w_head_rd;
                r_wdata <= w_ld_ext;
            end
            if (load_resp_valid && w_empty) r_resp_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
module tb_wb_sequencer;
    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          alu_valid, alu_we;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          load_req_valid, load_req_ready;
    logic [AW-1:0] load_rd;
    logic [2:0]    load_funct3;
    logic          load_resp_valid, load_resp_ready;
    logic [DW-1:0] load_resp_data;
    logic [AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic          hazard_stall, RegWrite, resp_error;
    logic [AW-1:0] write_reg_addr;
    logic [DW-1:0] write_reg_data;

    wb_sequencer #(.DATA_W(DW), .ADDR_W(AW), .LQ_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
        .load_req_valid(load_req_valid), .load_req_ready(load_req_ready),
        .load_rd(load_rd), .load_funct3(load_funct3),
        .load_resp_valid(load_resp_valid), .load_resp_ready(load_resp_ready),
        .load_resp_data(load_resp_data),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard_stall(hazard_stall), .RegWrite(RegWrite),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .resp_error(resp_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending loads as queues, plus the expected write-port contents.
    logic [AW-1:0] q_rd [$];
    logic [2:0]    q_f3 [$];
    logic          exp_we, exp_err;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] extend(input logic [2:0] f3, input logic [63:0] d);
        case (f3)
            3'd0:    return longint'(byte'(d[7:0]));
            3'd1:    return longint'(shortint'(d[15:0]));
            3'd2:    return longint'(int'(d[31:0]));
            3'd4:    return 64'(d[7:0]);
            3'd5:    return 64'(d[15:0]);
            3'd6:    return 64'(d[31:0]);
            default: return d;
        endcase
    endfunction

    function automatic logic model_hazard();
        logic [AW-1:0] src [3];
        src = '{dec_rs1, dec_rs2, dec_rd};
        foreach (src[s]) begin
            if (src[s] != 0) begin
                if (exp_we && exp_addr == src[s]) return 1'b1;
                foreach (q_rd[j]) if (q_rd[j] == src[s]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        q_rd.delete();
        q_f3.delete();
        exp_we   = 1'b0;
        exp_err  = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic idle();
        alu_valid = 0; alu_we = 0; alu_rd = '0; alu_data = '0;
        load_req_valid = 0; load_rd = '0; load_funct3 = '0;
        load_resp_valid = 0; load_resp_data = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic run_cycle();
        logic          alu_acc, nxt_we;
        int            n;
        n       = q_rd.size();
        alu_acc = alu_valid && alu_we && (alu_rd != 0);
        #1;
        check("load_req_ready", load_req_ready, n < DEPTH);
        check("load_resp_ready", load_resp_ready, (n > 0) && !alu_acc);
        check("hazard_stall", hazard_stall, model_hazard());
        nxt_we = 1'b0;
        if (alu_acc) begin
            nxt_we   = 1'b1;
            exp_addr = alu_rd;
            exp_data = alu_data;
        end else if (load_resp_valid && n > 0) begin
            if (q_rd[0] != 0) begin
                nxt_we   = 1'b1;
                exp_addr = q_rd[0];
                exp_data = extend(q_f3[0], load_resp_data);
            end
            void'(q_rd.pop_front());
            void'(q_f3.pop_front());
        end
        if (load_resp_valid && n == 0) exp_err = 1'b1;
        if (load_req_valid && n < DEPTH) begin
            q_rd.push_back(load_rd);
            q_f3.push_back(load_funct3);
        end
        exp_we = nxt_we;
        @(posedge clk);
        #1;
        check("RegWrite", RegWrite, exp_we);
        check("write_reg_addr", write_reg_addr, exp_addr);
        check("write_reg_data", write_reg_data, exp_data);
        check("resp_error", resp_error, exp_err);
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic [2:0] f3);
        idle();
        load_req_valid = 1; load_rd = rd; load_funct3 = f3;
        run_cycle();
    endtask

    task automatic respond(input logic [DW-1:0] d);
        idle();
        load_resp_valid = 1; load_resp_data = d;
        run_cycle();
    endtask

    task automatic pulse_reset();
        idle();
        reset_n = 0;
        #1;
        model_reset();
        check("rst_RegWrite", RegWrite, 1'b0);
        check("rst_req_ready", load_req_ready, 1'b1);
        check("rst_resp_error", resp_error, 1'b0);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        reset_n = 0;
        #2;
        check("reset_RegWrite", RegWrite, 1'b0);
        check("reset_addr", write_reg_addr, '0);
        check("reset_data", write_reg_data, '0);
        check("reset_err", resp_error, 1'b0);
        check("reset_req_ready", load_req_ready, 1'b1);
        check("reset_hazard", hazard_stall, 1'b0);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;

        // ALU write appears for exactly one cycle; rd=0 never writes.
        idle(); alu_valid = 1; alu_we = 1; alu_rd = 5'd3; alu_data = 64'h1234;
        run_cycle();
        check("alu_we_n1", RegWrite, 1'b1);
        check("alu_data_n1", write_reg_data, 64'h1234);
        idle(); run_cycle();
        check("alu_we_n2", RegWrite, 1'b0);
        idle(); alu_valid = 1; alu_we = 1; alu_rd = 5'd0; alu_data = 64'h55;
        run_cycle();
        check("alu_x0", RegWrite, 1'b0);

        // Load extension cases.
        issue(5'd5, 3'b000); respond(64'hF0);
        check("lb_sext", write_reg_data, 64'hFFFF_FFFF_FFFF_FFF0);
        issue(5'd5, 3'b100); respond(64'hF0);
        check("lbu_zext", write_reg_data, 64'h0000_0000_0000_00F0);
        issue(5'd5, 3'b010); respond(64'h8000_0000);
        check("lw_sext", write_reg_data, 64'hFFFF_FFFF_8000_0000);

        // ALU and load response collide: ALU first, held response next.
        issue(5'd6, 3'b011);
        idle(); alu_valid = 1; alu_we = 1; alu_rd = 5'd9; alu_data = 64'hA5;
        load_resp_valid = 1; load_resp_data = 64'hDEAD_BEEF_0000_0001;
        run_cycle();
        check("collide_alu_addr", write_reg_addr, 5'd9);
        idle(); load_resp_valid = 1; load_resp_data = 64'hDEAD_BEEF_0000_0001;
        run_cycle();
        check("collide_ld_addr", write_reg_addr, 5'd6);

        // Fill FIFO, 5th request ignored, drain in order.
        for (int i = 1; i <= 4; i++) issue(AW'(i), 3'b011);
        issue(5'd20, 3'b011);
        check("full_not_ready", load_req_ready, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            respond(64'(i * 16));
            check("drain_addr", write_reg_addr, AW'(i));
        end

        // Hazard on pending load, and x0 never stalls.
        issue(5'd7, 3'b011);
        idle(); dec_rs2 = 5'd7; run_cycle();
        idle(); dec_rs2 = 5'd7; load_resp_valid = 1; load_resp_data = 64'h7; run_cycle();
        idle(); dec_rs2 = 5'd7; run_cycle();
        issue(5'd0, 3'b011);
        idle(); run_cycle();
        respond(64'h1);
        check("x0_load_nowrite", RegWrite, 1'b0);

        // Error on empty FIFO, then reset mid-stream with two pending.
        respond(64'h99);
        check("empty_resp_err", resp_error, 1'b1);
        issue(5'd11, 3'b011); issue(5'd12, 3'b011);
        pulse_reset();
        respond(64'h42);

        // Randomized traffic with periodic resets.
        for (int blk = 0; blk < 4; blk++) begin
            pulse_reset();
            for (int c = 0; c < 250; c++) begin
                alu_valid       = ($urandom_range(0, 99) < 30);
                alu_we          = ($urandom_range(0, 9) != 0);
                alu_rd          = AW'($urandom_range(0, 7));
                alu_data        = {$urandom, $urandom};
                load_req_valid  = ($urandom_range(0, 99) < 40);
                load_rd         = AW'($urandom_range(0, 7));
                load_funct3     = 3'($urandom_range(0, 7));
                load_resp_valid = (q_rd.size() > 0) ? ($urandom_range(0, 99) < 50)
                                                    : ($urandom_range(0, 99) < 3);
                load_resp_data  = {$urandom, $urandom};
                dec_rs1         = AW'($urandom_range(0, 7));
                dec_rs2         = AW'($urandom_range(0, 7));
                dec_rd          = AW'($urandom_range(0, 7));
                run_cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
